// File: rtl/hazard_control_unit_if.sv
// Hazard-control bundle between the pipeline datapath and the sequencing controller.
// The datapath side (master) supplies hazard sources; the controller side (slave) returns enables.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_UsesRt;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_rd;
  logic             EX_BranchTaken;
  logic             EX_MulStart;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Flush;
  logic             Busy;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_rs, ID_rt, ID_UsesRt, ID_EX_MemRead, ID_EX_rd, EX_BranchTaken, EX_MulStart,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, Busy,
           StallCount, FlushCount
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRt, ID_EX_MemRead, ID_EX_rd, EX_BranchTaken, EX_MulStart,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, Busy,
           StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Five-stage pipeline sequencing controller: load-use bubbles, taken-branch squash,
// multi-cycle EX freeze, and saturating stall/flush counters.
module hazard_control_unit #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input logic                   Clk,
  input logic                   Rst,
  hazard_control_unit_if.slave  hz
);

  localparam int unsigned     CW       = 8;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MUL_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic flush_evt;
  logic load_use;

  // A load writing r0 never produces a usable value, so it cannot stall.
  assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_rd != 5'd0) &&
                    ((hz.ID_EX_rd == hz.ID_rs) ||
                     (hz.ID_UsesRt && (hz.ID_EX_rd == hz.ID_rt)));

  // Next-state and zero-latency enable decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_write = 1'b1;
    id_ex_flush = 1'b0;
    flush_evt   = 1'b0;

    if (!Rst) begin
      // Fill the pipeline with NOPs while reset is held.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hz.EX_MulStart) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            cnt_d       = CNT_LOAD;
            state_d     = MULTI;
          end else if (hz.EX_BranchTaken) begin
            // Squash wrong path; a coincident load-use belongs to the wrong path too.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt   = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MULTI: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Registered status and saturating performance counters.
  always_comb begin
    busy_d        = (state_d == MULTI);
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!pc_write && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (flush_evt && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.PCWrite     = pc_write;
  assign hz.IF_ID_Write = if_id_write;
  assign hz.IF_ID_Flush = if_id_flush;
  assign hz.ID_EX_Write = id_ex_write;
  assign hz.ID_EX_Flush = id_ex_flush;
  assign hz.Busy        = busy_q;
  assign hz.StallCount  = stall_count_q;
  assign hz.FlushCount  = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: three controller instances (latency 4, latency 2, 4-bit counters) on shared stimulus.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_ex_rd = '0;
  logic       uses_rt = 1'b0, mem_read = 1'b0, br_taken = 1'b0, mul_start = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(16)) if4  ();
  hazard_control_unit_if #(.CNT_W(16)) if2  ();
  hazard_control_unit_if #(.CNT_W(4))  ifs  ();

  assign {if4.ID_rs, if4.ID_rt, if4.ID_UsesRt, if4.ID_EX_MemRead, if4.ID_EX_rd, if4.EX_BranchTaken, if4.EX_MulStart}
       = {id_rs, id_rt, uses_rt, mem_read, id_ex_rd, br_taken, mul_start};
  assign {if2.ID_rs, if2.ID_rt, if2.ID_UsesRt, if2.ID_EX_MemRead, if2.ID_EX_rd, if2.EX_BranchTaken, if2.EX_MulStart}
       = {id_rs, id_rt, uses_rt, mem_read, id_ex_rd, br_taken, mul_start};
  assign {ifs.ID_rs, ifs.ID_rt, ifs.ID_UsesRt, ifs.ID_EX_MemRead, ifs.ID_EX_rd, ifs.EX_BranchTaken, ifs.EX_MulStart}
       = {id_rs, id_rt, uses_rt, mem_read, id_ex_rd, br_taken, mul_start};

  hazard_control_unit #(.MUL_LATENCY(4), .CNT_W(16)) u_dut4 (.Clk(clk), .Rst(rst), .hz(if4));
  hazard_control_unit #(.MUL_LATENCY(2), .CNT_W(16)) u_dut2 (.Clk(clk), .Rst(rst), .hz(if2));
  hazard_control_unit #(.MUL_LATENCY(4), .CNT_W(4))  u_duts (.Clk(clk), .Rst(rst), .hz(ifs));

  // Enables packed as {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush}.
  logic [4:0] en4, en2;
  assign en4 = {if4.PCWrite, if4.IF_ID_Write, if4.IF_ID_Flush, if4.ID_EX_Write, if4.ID_EX_Flush};
  assign en2 = {if2.PCWrite, if2.IF_ID_Write, if2.IF_ID_Flush, if2.ID_EX_Write, if2.ID_EX_Flush};

  localparam logic [4:0] EN_DEFAULT = 5'b11010;
  localparam logic [4:0] EN_RESET   = 5'b00111;
  localparam logic [4:0] EN_BUBBLE  = 5'b00011;
  localparam logic [4:0] EN_FLUSH   = 5'b11111;
  localparam logic [4:0] EN_FREEZE  = 5'b00000;

  // Simultaneous multi-cycle start and taken branch is illegal upstream.
  always @(posedge clk) begin
    if (rst) assert (!(mul_start && br_taken)) else $error("illegal EX_MulStart with EX_BranchTaken");
  end

  task automatic clear_inputs();
    {id_rs, id_rt, id_ex_rd} = '0;
    {uses_rt, mem_read, br_taken, mul_start} = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (en4 !== EN_RESET) begin errors++; $display("FAIL reset_enables: got %b want %b", en4, EN_RESET); end
    checks++; if ({if4.Busy, if4.StallCount, if4.FlushCount} !== 33'd0) begin errors++;
      $display("FAIL reset_regs: busy %b stall %0d flush %0d want 0", if4.Busy, if4.StallCount, if4.FlushCount); end
    rst = 1'b1;
    #1;
    checks++; if (en4 !== EN_DEFAULT) begin errors++; $display("FAIL reset_release: got %b want %b", en4, EN_DEFAULT); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    mem_read = 1'b1; id_ex_rd = 5'd8; id_rs = 5'd8;
    #1;
    checks++; if (en4 !== EN_BUBBLE) begin errors++; $display("FAIL load_use_rs: got %b want %b", en4, EN_BUBBLE); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (en4 !== EN_DEFAULT) begin errors++; $display("FAIL load_use_one_cycle: got %b want %b", en4, EN_DEFAULT); end
    checks++; if (if4.StallCount !== 16'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", if4.StallCount); end
    // rt match but rt not read: no stall
    mem_read = 1'b1; id_ex_rd = 5'd8; id_rs = 5'd3; id_rt = 5'd8; uses_rt = 1'b0;
    #1;
    checks++; if (en4 !== EN_DEFAULT) begin errors++; $display("FAIL load_use_rt_unused: got %b want %b", en4, EN_DEFAULT); end
    uses_rt = 1'b1;
    #1;
    checks++; if (en4 !== EN_BUBBLE) begin errors++; $display("FAIL load_use_rt_used: got %b want %b", en4, EN_BUBBLE); end
    @(negedge clk);
    mem_read = 1'b1; id_ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; uses_rt = 1'b1;
    #1;
    checks++; if (en4 !== EN_DEFAULT) begin errors++; $display("FAIL load_use_r0: got %b want %b", en4, EN_DEFAULT); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (if4.StallCount !== 16'd2) begin errors++; $display("FAIL load_use_stall_cnt2: got %0d want 2", if4.StallCount); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    br_taken = 1'b1; mem_read = 1'b1; id_ex_rd = 5'd8; id_rs = 5'd8;
    #1;
    checks++; if (en4 !== EN_FLUSH) begin errors++; $display("FAIL branch_flush: got %b want %b", en4, EN_FLUSH); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (if4.FlushCount !== 16'd1) begin errors++; $display("FAIL branch_flush_cnt: got %0d want 1", if4.FlushCount); end
    checks++; if (if4.StallCount !== 16'd2) begin errors++; $display("FAIL branch_stall_cnt: got %0d want 2", if4.StallCount); end
  endtask

  task automatic test_multi4();
    @(negedge clk);
    mul_start = 1'b1;
    #1;
    checks++; if ({en4, if4.Busy} !== {EN_FREEZE, 1'b0}) begin errors++;
      $display("FAIL multi4_start: got %b/%b want %b/0", en4, if4.Busy, EN_FREEZE); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      mul_start = 1'b0;
      br_taken  = (i == 1);
      #1;
      checks++; if ({en4, if4.Busy} !== {EN_FREEZE, 1'b1}) begin errors++;
        $display("FAIL multi4_frozen_%0d: got %b/%b want %b/1", i, en4, if4.Busy, EN_FREEZE); end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if ({en4, if4.Busy} !== {EN_DEFAULT, 1'b0}) begin errors++;
      $display("FAIL multi4_release: got %b/%b want %b/0", en4, if4.Busy, EN_DEFAULT); end
    checks++; if (if4.StallCount !== 16'd6) begin errors++; $display("FAIL multi4_stall_cnt: got %0d want 6", if4.StallCount); end
    checks++; if (if4.FlushCount !== 16'd1) begin errors++; $display("FAIL multi4_no_flush: got %0d want 1", if4.FlushCount); end
  endtask

  task automatic test_multi2();
    // u_dut2 entered with StallCount 4 (two bubbles plus the earlier 2-cycle freeze).
    @(negedge clk);
    mul_start = 1'b1;
    #1;
    checks++; if (en2 !== EN_FREEZE) begin errors++; $display("FAIL multi2_start: got %b want %b", en2, EN_FREEZE); end
    @(negedge clk);
    mul_start = 1'b0;
    #1;
    checks++; if ({en2, if2.Busy} !== {EN_FREEZE, 1'b1}) begin errors++;
      $display("FAIL multi2_frozen: got %b/%b want %b/1", en2, if2.Busy, EN_FREEZE); end
    @(negedge clk);
    #1;
    checks++; if ({en2, if2.Busy} !== {EN_DEFAULT, 1'b0}) begin errors++;
      $display("FAIL multi2_release: got %b/%b want %b/0", en2, if2.Busy, EN_DEFAULT); end
    checks++; if (if2.StallCount !== 16'd6) begin errors++; $display("FAIL multi2_stall_cnt: got %0d want 6", if2.StallCount); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_multi();
    @(negedge clk);
    mul_start = 1'b1;
    @(negedge clk);
    mul_start = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (en4 !== EN_RESET) begin errors++; $display("FAIL abort_forced: got %b want %b", en4, EN_RESET); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({en4, if4.Busy} !== {EN_DEFAULT, 1'b0}) begin errors++;
      $display("FAIL abort_run: got %b/%b want %b/0", en4, if4.Busy, EN_DEFAULT); end
    checks++; if ({if4.StallCount, if4.FlushCount} !== 32'd0) begin errors++;
      $display("FAIL abort_counters: stall %0d flush %0d want 0", if4.StallCount, if4.FlushCount); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      mem_read = 1'b1; id_ex_rd = 5'd5; id_rt = 5'd5; uses_rt = 1'b1;
      @(negedge clk);
      clear_inputs();
      if (i == 14) begin
        #1;
        checks++; if (ifs.StallCount !== 4'd14) begin errors++; $display("FAIL sat_pre: got %0d want 14", ifs.StallCount); end
      end
    end
    #1;
    checks++; if (ifs.StallCount !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", ifs.StallCount); end
    checks++; if (if4.StallCount !== 16'd20) begin errors++; $display("FAIL sat_wide_ref: got %0d want 20", if4.StallCount); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_multi4();
    test_multi2();
    test_reset_in_multi();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencing controller for the five-stage MIPS datapath. It owns the write and flush enables of the PC, the IF/ID register and the ID/EX stage register. It inserts a bubble on a load-use hazard, squashes wrong-path instructions on a taken branch, and freezes the front end while a multi-cycle ALU operation occupies EX. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- MUL_LATENCY, 4: total EX occupancy in cycles of a multi-cycle op; legal range 2..255.
- CNT_W, 16: width of the StallCount and FlushCount counters.

Ports:
- Clk  in  1  rising-edge clock, shared with all stage registers.
- Rst  in  1  synchronous, active-low reset, sampled on the Clk rising edge.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt (R-type, store, branch).
- ID_EX_MemRead  in  1  the instruction in EX is a load.
- ID_EX_rd  in  5  destination register of the EX instruction, after the RegDst mux.
- EX_BranchTaken  in  1  a branch or jump resolved as taken in EX this cycle.
- EX_MulStart  in  1  a multi-cycle op entered EX this cycle; single-cycle pulse.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  IF/ID loads a NOP.
- ID_EX_Write  out  1  ID/EX load enable.
- ID_EX_Flush  out  1  ID/EX loads all-zero control fields (bubble).
- Busy  out  1  high while in MULTI.
- StallCount  out  CNT_W  saturating count of cycles with PCWrite==0 outside reset.
- FlushCount  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- There are two states: RUN and MULTI. A down-counter `cnt` is 8 bits wide.
- The load-use condition is: ID_EX_MemRead && ID_EX_rd!=0 && (ID_EX_rd==ID_rs || (ID_UsesRt && ID_EX_rd==ID_rt)).
- Default outputs are: PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, both flushes=0.
- In RUN, the first matching rule applies, in priority order:
  1. EX_MulStart: freeze. PCWrite=0, IF_ID_Write=0, ID_EX_Write=0. Load cnt<=MUL_LATENCY-2. Next state is MULTI.
  2. EX_BranchTaken: IF_ID_Flush=1 and ID_EX_Flush=1, with PC and register writes still enabled so the target is fetched. FlushCount increments. Next state is RUN.
  3. Load-use: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 (one bubble). Next state is RUN; the condition clears naturally the following cycle.
- In MULTI:
  - Outputs are frozen: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, flushes=0.
  - EX_BranchTaken, load-use and EX_MulStart are ignored.
  - If cnt==0, next state is RUN; otherwise cnt<=cnt-1.
- Total frozen cycles per multi-cycle op equals MUL_LATENCY: the start cycle plus MUL_LATENCY-1 cycles in MULTI.
- StallCount increments by 1 in every non-reset cycle with PCWrite==0 and holds at all-ones.
- FlushCount increments by 1 per flush cycle and holds at all-ones.
- Outputs PCWrite through ID_EX_Flush are combinational from state and inputs.
- Busy, StallCount and FlushCount are registered.

## Timing
- Reset (Rst==0 at a posedge): next state is RUN, cnt=0, StallCount=0, FlushCount=0, Busy=0.
- While Rst==0, outputs are forced to: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Write=1, ID_EX_Flush=1. The pipeline fills with NOPs.
- A reset in the middle of MULTI aborts the freeze immediately. The first cycle after Rst returns high is in RUN with default outputs.
- Hazard response has zero latency: enables change in the same cycle the condition is present, ahead of the next Clk edge.
- Busy rises one cycle after EX_MulStart and falls on the edge that returns the state to RUN.
- Simultaneous EX_MulStart and EX_BranchTaken: MulStart wins and no flush is issued; this combination is illegal upstream, and the bench flags it with an assertion.
- Simultaneous EX_BranchTaken and load-use: the flush wins, because the ID instruction is wrong-path. No bubble is counted as a stall.
- ID_EX_rd==0 never triggers a stall.

## Test plan
- Reset: hold Rst=0 for 2 cycles. Required: PCWrite=0, IF_ID_Flush=1, ID_EX_Flush=1, both counters 0, Busy=0. After release, the first cycle shows default outputs.
- Load-use: ID_EX_MemRead=1, ID_EX_rd=8, ID_rs=8. Required: exactly one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount=1. Repeat with ID_rt=8, ID_UsesRt=0: no stall. Repeat with rd=0, rs=0: no stall.
- Branch: EX_BranchTaken=1 for one cycle with a simultaneous load-use. Required: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1; FlushCount=1; StallCount unchanged.
- Multi-cycle, MUL_LATENCY=4: pulse EX_MulStart. Required: exactly 4 consecutive cycles of PCWrite=0 and ID_EX_Write=0; Busy high for 3 cycles; StallCount=4. An EX_BranchTaken driven during MULTI produces no flush.
- Multi-cycle, MUL_LATENCY=2: required 2 frozen cycles. Then assert Rst=0 during the first MULTI cycle of a MUL_LATENCY=4 run: state returns to RUN and counters clear.
- Saturation: with CNT_W=4, drive 20 load-use stalls. Required: StallCount=15, with no wrap.
